// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: FSM state encoding,
// requester/owner codes and the inactive level of the active-low strobes.
package ram_arb_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ADDR   = 2'b01,
    ST_ACCESS = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  // Owner codes, also driven directly onto the owner output.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_LDR  = 2'b10
  } owner_e;

  // All memory strobes are active low, matching the control-word polarity.
  localparam logic STROBE_OFF = 1'b1;

  // Hold counter width; covers the legal HOLD_CYCLES range 1..7.
  localparam int CNT_W = 3;

endpackage : ram_arb_pkg

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin grant logic with last-owner register.
// With lock_i high, a pending loader request always wins and a completing
// loader transaction leaves the round-robin pointer on the CPU.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   cpu_req_i,
  input  logic   ldr_req_i,
  input  logic   lock_i,
  input  logic   update_i,
  input  owner_e done_owner_i,
  output owner_e grant_o
);

  owner_e last_q, last_d;

  // Grant decision: single requester wins outright, a tie goes to whoever
  // did not own the bus last (or to the loader while locked).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant_o = OWN_NONE;
    if (cpu_req_i && ldr_req_i) begin
      grant_o = (lock_i || (last_q == OWN_CPU)) ? OWN_LDR : OWN_CPU;
    end else if (cpu_req_i) begin
      grant_o = OWN_CPU;
    end else if (ldr_req_i) begin
      grant_o = OWN_LDR;
    end
  end

  // Pointer update on transaction completion.
  always_comb begin
    last_d = last_q;
    if (update_i && (done_owner_i != OWN_NONE)) begin
      last_d = (lock_i && (done_owner_i == OWN_LDR)) ? OWN_CPU : done_owner_i;
    end
  end

  // Last-owner register; after reset the loader wins the first tie.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its inputs from before the edge.
    if (!rst_n) begin
      last_q <= OWN_CPU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arb2

// File: rtl/ram_port_arbiter.sv
// Shares one MAR/RAM pair between the CPU control block and an external
// program loader. Each access: MAR load strobe for one cycle, then the RAM
// read or write strobe for HOLD_CYCLES cycles, then a one-cycle ack.
// Optional feature macro: ARB_LOCK_EN adds the ldr_lock input, which keeps
// the bus with the loader while held.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 1   // legal range 1..7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
`ifdef ARB_LOCK_EN
  input  logic              ldr_lock,
`endif
  output logic              ldr_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              mar_addr_load_n,
  output logic              ram_en_n,
  output logic              ram_load_n,
  output logic              busy,
  output logic [1:0]        owner
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  owner_e grant;
  logic   lock;

`ifdef ARB_LOCK_EN
  assign lock = ldr_lock;
`else
  assign lock = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req_i    (cpu_req),
    .ldr_req_i    (ldr_req),
    .lock_i       (lock),
    .update_i     (state_q == ST_DONE),
    .done_owner_i (owner_q),
    .grant_o      (grant)
  );

  // Next-state logic: grant and latch the request, then sequence the
  // MAR load, the timed RAM access and the completion cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant == OWN_CPU) begin
          owner_d = OWN_CPU;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = ST_ADDR;
        end else if (grant == OWN_LDR) begin
          owner_d = OWN_LDR;
          we_d    = ldr_we;
          addr_d  = ldr_addr;
          wdata_d = ldr_wdata;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        cnt_d   = HOLD_LAST;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            rdata_d = ram_rdata;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes and acks decode straight from the registered state, so at most
  // one strobe can be low and everything releases on the reset edge.
  always_comb begin
    mar_addr_load_n = STROBE_OFF;
    ram_en_n        = STROBE_OFF;
    ram_load_n      = STROBE_OFF;
    cpu_ack         = 1'b0;
    ldr_ack         = 1'b0;
    case (state_q)
      ST_ADDR:   mar_addr_load_n = ~STROBE_OFF;
      ST_ACCESS: begin
        if (we_q) ram_load_n = ~STROBE_OFF;
        else      ram_en_n   = ~STROBE_OFF;
      end
      ST_DONE: begin
        cpu_ack = (owner_q == OWN_CPU);
        ldr_ack = (owner_q == OWN_LDR);
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign owner     = owner_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule : ram_port_arbiter
